// File: rtl/demux_1_4_stream_if.sv
// Bundle of the single input stream and the four output lanes of demux_1_4_stream.
// Handshake: a word moves on an interface at a rising edge where its valid and ready are both high;
// a producer keeps valid, data and select stable while valid is high and ready is low.
interface demux_1_4_stream_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer: a pair register per lane pair (L0, L1) feeding
// four output registers (O0..O3); no combinational path from input data to output data.
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_1_4_stream_if.slave   bus
);

  logic [1:0]            l_valid_q, l_valid_d;
  logic [1:0]            l_sel0_q,  l_sel0_d;
  logic [1:0][WIDTH-1:0] l_data_q,  l_data_d;
  logic [3:0]            o_valid_q, o_valid_d;
  logic [3:0][WIDTH-1:0] o_data_q,  o_data_d;

  logic [3:0] o_leave;
  logic [3:0] o_can;
  logic [3:0] o_load;
  logic [1:0] l_move;
  logic [1:0] l_can;
  logic [1:0] l_load;
  logic       in_fire;

  // in_ready depends only on the pair the current select addresses, so a stalled pair
  // never throttles traffic headed for the other pair.
  assign bus.in_ready = bus.in_sel[1] ? l_can[1] : l_can[0];
  assign in_fire      = bus.in_valid & bus.in_ready;

  for (genvar j = 0; j < 2; j++) begin : g_pair
    assign l_move[j]    = l_valid_q[j] & (l_sel0_q[j] ? o_can[2*j+1] : o_can[2*j]);
    assign l_can[j]     = ~l_valid_q[j] | l_move[j];
    assign l_load[j]    = in_fire & (bus.in_sel[1] == 1'(j));
    assign l_valid_d[j] = l_load[j] | (l_valid_q[j] & ~l_move[j]);
    assign l_data_d[j]  = l_load[j] ? bus.in_data    : l_data_q[j];
    assign l_sel0_d[j]  = l_load[j] ? bus.in_sel[0]  : l_sel0_q[j];
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign o_leave[i]   = o_valid_q[i] & bus.out_ready[i];
    assign o_can[i]     = ~o_valid_q[i] | o_leave[i];
    assign o_load[i]    = l_move[i/2] & (l_sel0_q[i/2] == 1'(i % 2));
    // Leaving and loading on the same edge keeps valid high with the new word.
    assign o_valid_d[i] = o_load[i] | (o_valid_q[i] & ~o_leave[i]);
    assign o_data_d[i]  = o_load[i] ? l_data_q[i/2] : o_data_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_valid_q <= '0;
      l_sel0_q  <= '0;
      l_data_q  <= '0;
      o_valid_q <= '0;
      o_data_q  <= '0;
    end else begin
      l_valid_q <= l_valid_d;
      l_sel0_q  <= l_sel0_d;
      l_data_q  <= l_data_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  assign bus.out_valid = o_valid_q;
  assign bus.out_data  = o_data_q;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: table-driven input vectors, per-lane expected
// queues filled on accepted inputs and drained on delivered outputs, plus corner sequences.
module tb_demux_1_4_stream;
  localparam int W = 4;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
    logic [3:0]   ordy;
    logic         exp_rdy;
  } vec_t;

  logic clk;
  logic rst_n;
  demux_1_4_stream_if #(.WIDTH(W)) ifc ();

  demux_1_4_stream #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [3:0] lane_strict = 4'b0000;

  logic [W-1:0] exp_q [4][$];
  int           acc_q [4][$];
  vec_t         tbl [12];

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.in_valid && ifc.in_ready) begin
        exp_q[ifc.in_sel].push_back(ifc.in_data);
        acc_q[ifc.in_sel].push_back(cyc);
      end
      for (int i = 0; i < 4; i++) begin
        if (ifc.out_valid[i] && ifc.out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("lane%0d_unexpected_word", i), 32'(ifc.out_data[i*W +: W]), 32'hDEAD);
          end else begin
            logic [W-1:0] e;
            int a;
            e = exp_q[i].pop_front();
            a = acc_q[i].pop_front();
            chk($sformatf("lane%0d_data", i), 32'(ifc.out_data[i*W +: W]), 32'(e));
            if (lane_strict[i]) chk($sformatf("lane%0d_latency", i), 32'(cyc - a), 32'd2);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
    @(posedge clk);
    #1;
    ifc.in_valid  = v;
    ifc.in_sel    = s;
    ifc.in_data   = d;
    ifc.out_ready = r;
  endtask

  task automatic idle(input logic [3:0] r, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 2'd0, '0, r);
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int k);
    drive(1'b1, tbl[k].sel, tbl[k].data, tbl[k].ordy);
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", k), 32'(ifc.in_ready), 32'(tbl[k].exp_rdy));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_sel    = 2'd0;
    ifc.in_data   = '0;
    ifc.out_ready = 4'b0000;
    rst_n         = 1'b0;

    // streaming, all lanes ready
    tbl[0]  = '{2'd0, 4'h1, 4'b1111, 1'b1};
    tbl[1]  = '{2'd1, 4'h2, 4'b1111, 1'b1};
    tbl[2]  = '{2'd2, 4'h3, 4'b1111, 1'b1};
    tbl[3]  = '{2'd3, 4'h4, 4'b1111, 1'b1};
    tbl[4]  = '{2'd3, 4'h5, 4'b1111, 1'b1};
    tbl[5]  = '{2'd0, 4'h6, 4'b1111, 1'b1};
    // lane 0 stalled: two words fit, then its pair blocks while the other pair flows
    tbl[6]  = '{2'd0, 4'h5, 4'b1110, 1'b1};
    tbl[7]  = '{2'd0, 4'h6, 4'b1110, 1'b1};
    tbl[8]  = '{2'd0, 4'hB, 4'b1110, 1'b0};
    tbl[9]  = '{2'd1, 4'hC, 4'b1110, 1'b0};
    tbl[10] = '{2'd2, 4'h7, 4'b1110, 1'b1};
    tbl[11] = '{2'd3, 4'h8, 4'b1110, 1'b1};

    // reset held across edges
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
      chk("rst_out_data", 32'(ifc.out_data), 32'h0);
      chk("rst_in_ready", 32'(ifc.in_ready), 32'h1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(ifc.out_valid), 32'h0);
      chk("post_rst_in_ready", 32'(ifc.in_ready), 32'h1);
    end

    // single word to lane 2, latency and hold
    drive(1'b1, 2'd2, 4'hA, 4'b0000);
    @(negedge clk);
    chk("single_in_ready", 32'(ifc.in_ready), 32'h1);
    drive(1'b0, 2'd0, '0, 4'b0000);
    @(negedge clk);
    chk("single_not_yet_valid", 32'(ifc.out_valid), 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 2'd0, '0, 4'b0000);
      @(negedge clk);
      chk("single_hold_valid", 32'(ifc.out_valid), 32'b0100);
      chk("single_hold_data", 32'(ifc.out_data[2*W +: W]), 32'hA);
    end
    drive(1'b0, 2'd0, '0, 4'b0100);
    @(negedge clk);
    drive(1'b0, 2'd0, '0, 4'b0000);
    @(negedge clk);
    chk("single_cleared", 32'(ifc.out_valid), 32'h0);

    // streaming at full rate, exact 2-cycle latency
    lane_strict = 4'b1111;
    for (int k = 0; k < 6; k++) run_vec(k);
    idle(4'b1111, 4);
    lane_strict = 4'b0000;

    // backpressure isolation
    lane_strict = 4'b1100;
    for (int k = 6; k < 12; k++) run_vec(k);
    // lane 0 released while L0 holds 6 and a lane-1 word is presented
    drive(1'b1, 2'd1, 4'h9, 4'b1111);
    @(negedge clk);
    chk("simul_in_ready", 32'(ifc.in_ready), 32'h1);
    drive(1'b0, 2'd0, '0, 4'b1111);
    @(negedge clk);
    chk("simul_out_valid_a", 32'(ifc.out_valid), 32'b1001);
    chk("simul_o0_data", 32'(ifc.out_data[0 +: W]), 32'h6);
    chk("simul_o3_data", 32'(ifc.out_data[3*W +: W]), 32'h8);
    drive(1'b0, 2'd0, '0, 4'b1111);
    @(negedge clk);
    chk("simul_out_valid_b", 32'(ifc.out_valid), 32'b0010);
    chk("simul_o1_data", 32'(ifc.out_data[W +: W]), 32'h9);
    idle(4'b1111, 3);
    lane_strict = 4'b0000;

    // asynchronous reset with words in L0, L1 and O2
    drive(1'b1, 2'd2, 4'h3, 4'b0000);
    @(negedge clk);
    chk("ar_accept_a", 32'(ifc.in_ready), 32'h1);
    drive(1'b1, 2'd2, 4'h4, 4'b0000);
    @(negedge clk);
    chk("ar_accept_b", 32'(ifc.in_ready), 32'h1);
    drive(1'b1, 2'd0, 4'hC, 4'b0000);
    @(negedge clk);
    chk("ar_accept_c", 32'(ifc.in_ready), 32'h1);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    #1 chk("ar_pre_out_valid", 32'(ifc.out_valid), 32'b0100);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      acc_q[i].delete();
    end
    #1;
    chk("ar_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("ar_out_data", 32'(ifc.out_data), 32'h0);
    chk("ar_in_ready", 32'(ifc.in_ready), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 2'd0, '0, 4'b1111);
      @(negedge clk);
      chk("ar_no_stale", 32'(ifc.out_valid), 32'h0);
    end

    // every accepted word delivered
    for (int i = 0; i < 4; i++)
      chk($sformatf("lane%0d_drained", i), 32'(exp_q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Registered 1-to-4 stream demultiplexer. It takes one valid/ready input stream with a 2-bit lane select and delivers each word to one of four valid/ready output lanes. Internally it is a two-level tree of 1:2 routing stages with a register at each level. It sits downstream of a single producer and fans that producer's traffic out to four independent consumers.

## Interface
- `WIDTH`, default 4: data word width in bits.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  input word present.
- `in_ready`  output  1  block accepts the input word this cycle.
- `in_data`  input  WIDTH  input word.
- `in_sel`  input  2  destination lane, 0..3.
- `out_valid`  output  4  bit i: lane i holds a word.
- `out_ready`  input  4  bit i: lane i consumer accepts.
- `out_data`  output  4*WIDTH  lane i word at `[i*WIDTH +: WIDTH]`.

## Operation
**Structure**
- Level 1 has two registers: L0 serves lanes 0/1 and L1 serves lanes 2/3. Each holds `{valid, data, sel0}`.
- Level 2 has four output registers O0..O3. Each holds `{valid, data}` and drives `out_valid[i]`/`out_data` lane i directly. There is no combinational path from `in_data` to `out_data`.

**Transfers**
- A transfer on any interface occurs when valid and ready are both high at a rising edge.
- Oi leaves when `out_valid[i] && out_ready[i]`.
- Oi can accept when it is empty or leaving.
- Lj moves to O(2j+sel0) when Lj is valid and that O register can accept.
- Lj can accept when it is empty or moving.

**Input side**
- `in_ready = in_sel[1] ? L1_can_accept : L0_can_accept`.
- `in_ready` is combinational from `in_sel`, `out_ready` and state. Producer rule: `in_sel` and `in_data` stay stable while `in_valid` is high and `in_ready` is low.
- On an accepted input, L(in_sel[1]) loads `{1, in_data, in_sel[0]}`.

**Register updates**
- A register that both leaves and loads in the same edge takes the new word, and its valid stays 1.
- A register that leaves without loading clears valid.
- A register that neither leaves nor loads holds its data and valid.

**Ordering and blocking**
- Words to the same lane are delivered in acceptance order.
- Words to different lanes may be delivered out of acceptance order.
- A stalled lane blocks only its pair. A word in Lj waiting for a full Oi also blocks its sibling lane (head-of-line within a pair).
- Lanes in the other pair keep full throughput.

**Reset**
- While `rst_n` is low, all valid bits are 0 and all data registers are 0.
- Assertion takes effect immediately, without waiting for a clock edge. In-flight words are discarded.

**Widths**
- Data passes bit-exact; there is no arithmetic.
- `in_sel` values 0..3 are all legal. There is no error or out-of-range case.

## Timing
**Reset values**
- `out_valid = 4'b0000`.
- `out_data = 0`.
- `in_ready = 1`, combinationally, because L0/L1 are empty.

**Latency**
- Input accepted at edge k: the word is in Lj after edge k and in Oi after edge k+1.
- `out_valid[i]` rises in the cycle after edge k+1. Minimum latency is 2 cycles.

**Throughput and backpressure**
- Throughput is 1 word/cycle sustained when the destination lanes are ready, including alternating lanes and back-to-back words to the same lane.
- Per-lane buffering is 2 words: Oi plus its pair's Lj.
- With `out_ready[i]` held low and the pair idle, two words to lane i are accepted. `in_ready` then drops for that pair's selects.

**Stall recovery**
- Oi is full, `out_ready[i]` rises, Lj holds a word for Oi, and a new input for Lj is presented, all in the same cycle.
- At that edge all three moves happen together: Oi→consumer, Lj→Oi, input→Lj. No word is lost or duplicated.

**Output stability**
- `out_valid[i]` and lane data stay stable until the word is taken.

## Test plan
- **Reset:** hold `rst_n`=0 across edges → `out_valid`=0000, `out_data`=0, `in_ready`=1. Release, then idle → state unchanged.
- **Single word:** send data 4'hA, sel 2, accepted at edge 0, with `out_ready`=0000 → after edge 2 `out_valid`=0100 and lane 2 = A. The word holds for 5 cycles, then clears one edge after `out_ready[2]`=1.
- **Streaming:** `out_ready`=1111; send sel 0,1,2,3,3,0 with data 1..6 back-to-back → `in_ready` stays 1. Outputs appear 2 cycles after each accept, one per cycle, in order on the correct lanes.
- **Backpressure isolation:** `out_ready[0]`=0, others 1; send 5,6 to lane 0 → both accepted. A third word to lane 0 or lane 1 sees `in_ready`=0. Words 7,8 to lanes 2,3 are still accepted and delivered at 2-cycle latency. Raising `out_ready[0]` → 5 then 6 are delivered, and the stalled word is accepted the same cycle.
- **Simultaneous move:** O0 holds 5, L0 holds 6 for lane 0, input 9 for lane 1 presented, `out_ready[0]` rises → after one edge: 5 consumed, O0=6, L0=9. One edge later O1=9.
- **Async reset mid-stream:** pull `rst_n` low between edges with words in L0, L1 and O2 → `out_valid`=0 immediately. After release, no stale word ever appears on any lane.
